// File: rtl/writeback_stage_if.sv
// rtl/writeback_stage_if.sv - write-back stage signal bundle
interface writeback_stage_if #(
   parameter int WIDTH      = 32,
   parameter int REG_ADDR_W = 4
);
   logic                  stall;
   logic                  flush;
   logic                  in_valid;
   logic                  wd_selector;
   logic [WIDTH-1:0]      read_data;
   logic [WIDTH-1:0]      alu_result;
   logic [1:0]            load_size;
   logic                  load_signed;
   logic [1:0]            byte_offset;
   logic                  in_reg_write;
   logic [REG_ADDR_W-1:0] in_rd_addr;
   logic [WIDTH-1:0]      selected_data;
   logic                  misaligned;
   logic                  rf_we;
   logic [REG_ADDR_W-1:0] rf_waddr;
   logic [WIDTH-1:0]      rf_wdata;
   logic                  fwd_valid;
   logic [REG_ADDR_W-1:0] fwd_addr;
   logic [WIDTH-1:0]      fwd_data;
   logic [31:0]           retired_count;

   modport master (
      output stall, flush, in_valid, wd_selector, read_data, alu_result,
             load_size, load_signed, byte_offset, in_reg_write, in_rd_addr,
      input  selected_data, misaligned, rf_we, rf_waddr, rf_wdata,
             fwd_valid, fwd_addr, fwd_data, retired_count
   );

   modport slave (
      input  stall, flush, in_valid, wd_selector, read_data, alu_result,
             load_size, load_signed, byte_offset, in_reg_write, in_rd_addr,
      output selected_data, misaligned, rf_we, rf_waddr, rf_wdata,
             fwd_valid, fwd_addr, fwd_data, retired_count
   );
endinterface

// File: rtl/writeback_stage.sv
// rtl/writeback_stage.sv - pipeline write-back: load extraction, RF write port, forwarding, retire count
module writeback_stage #(
   parameter int WIDTH      = 32,
   parameter int REG_ADDR_W = 4
) (
   input logic               clk,
   input logic               rst,
   writeback_stage_if.slave  bus
);
   logic [7:0]            byte_lane;
   logic [15:0]           half_lane;
   logic [WIDTH-1:0]      sel_data;

   logic                  we_q;
   logic [REG_ADDR_W-1:0] waddr_q;
   logic [WIDTH-1:0]      wdata_q;
   logic [31:0]           count_q;

   always_comb begin
      byte_lane = bus.read_data[7:0];
      case (bus.byte_offset)
         2'd1:    byte_lane = bus.read_data[15:8];
         2'd2:    byte_lane = bus.read_data[23:16];
         2'd3:    byte_lane = bus.read_data[31:24];
         default: byte_lane = bus.read_data[7:0];
      endcase
      // Half loads ignore offset bit 0; a set bit 0 is only flagged as misaligned.
      half_lane = bus.byte_offset[1] ? bus.read_data[31:16] : bus.read_data[15:0];

      sel_data = bus.alu_result;
      if (bus.wd_selector) begin
         case (bus.load_size)
            2'b00:   sel_data = {{(WIDTH-8){bus.load_signed & byte_lane[7]}}, byte_lane};
            2'b01:   sel_data = {{(WIDTH-16){bus.load_signed & half_lane[15]}}, half_lane};
            default: sel_data = bus.read_data;
         endcase
      end
   end

   assign bus.selected_data = sel_data;
   assign bus.misaligned    = bus.wd_selector & (bus.load_size == 2'b01) & bus.byte_offset[0];

   always_ff @(posedge clk) begin
      if (!rst) begin
         we_q    <= 1'b0;
         waddr_q <= '0;
         wdata_q <= '0;
         count_q <= '0;
      end else if (bus.flush || bus.stall) begin
         we_q <= 1'b0;
      end else begin
         we_q    <= bus.in_valid & bus.in_reg_write;
         waddr_q <= bus.in_rd_addr;
         wdata_q <= sel_data;
         if (bus.in_valid)
            count_q <= count_q + 32'd1;
      end
   end

   assign bus.rf_we         = we_q;
   assign bus.rf_waddr      = waddr_q;
   assign bus.rf_wdata      = wdata_q;
   assign bus.fwd_valid     = we_q;
   assign bus.fwd_addr      = waddr_q;
   assign bus.fwd_data      = wdata_q;
   assign bus.retired_count = count_q;
endmodule

// File: tb/tb_writeback_stage.sv
// tb/tb_writeback_stage.sv - self-checking bench for writeback_stage
module tb_writeback_stage;
   logic clk = 1'b0;
   logic rst = 1'b0;
   int   passed = 0;
   int   total  = 0;

   logic        m_we;
   logic [3:0]  m_addr;
   logic [31:0] m_data;
   logic [31:0] m_count;

   always #5 clk = ~clk;

   writeback_stage_if #(.WIDTH(32), .REG_ADDR_W(4)) bus ();
   writeback_stage #(.WIDTH(32), .REG_ADDR_W(4)) dut (.clk(clk), .rst(rst), .bus(bus));

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) passed++;
      else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
   endtask

   function automatic logic [31:0] ref_sel(input logic sel, input logic [31:0] rd, input logic [31:0] alu,
                                           input logic [1:0] size, input logic sgn, input logic [1:0] off);
      longint unsigned v;
      if (!sel) return alu;
      if (size >= 2) return rd;
      if (size == 0) begin
         v = (longint'(rd) >> (8 * off)) % 256;
         if (sgn && v >= 128) v = v + 64'hFFFF_FFFF_FFFF_FF00;
      end else begin
         v = (longint'(rd) >> (16 * (off / 2))) % 65536;
         if (sgn && v >= 32768) v = v + 64'hFFFF_FFFF_FFFF_0000;
      end
      return v[31:0];
   endfunction

   function automatic logic ref_mis(input logic sel, input logic [1:0] size, input logic [1:0] off);
      return sel && size == 2'b01 && (off % 2 == 1);
   endfunction

   task automatic set_in(input logic st, input logic fl, input logic v, input logic sel,
                         input logic [31:0] rd, input logic [31:0] alu, input logic [1:0] size,
                         input logic sgn, input logic [1:0] off, input logic rw, input logic [3:0] a);
      bus.stall = st; bus.flush = fl; bus.in_valid = v; bus.wd_selector = sel;
      bus.read_data = rd; bus.alu_result = alu; bus.load_size = size; bus.load_signed = sgn;
      bus.byte_offset = off; bus.in_reg_write = rw; bus.in_rd_addr = a;
   endtask

   task automatic check_comb(input string tag);
      #1;
      check({tag, "_sel"}, 64'(bus.selected_data),
            64'(ref_sel(bus.wd_selector, bus.read_data, bus.alu_result, bus.load_size, bus.load_signed, bus.byte_offset)));
      check({tag, "_mis"}, 64'(bus.misaligned), 64'(ref_mis(bus.wd_selector, bus.load_size, bus.byte_offset)));
   endtask

   // Advance one clock, update the reference, then compare every registered output.
   task automatic step(input string tag);
      if (!rst) begin
         m_we = 0; m_addr = 0; m_data = 0; m_count = 0;
      end else if (bus.flush || bus.stall) begin
         m_we = 0;
      end else begin
         m_we   = bus.in_valid && bus.in_reg_write;
         m_addr = bus.in_rd_addr;
         m_data = ref_sel(bus.wd_selector, bus.read_data, bus.alu_result, bus.load_size, bus.load_signed, bus.byte_offset);
         if (bus.in_valid) m_count = m_count + 1;
      end
      @(posedge clk);
      @(negedge clk);
      check({tag, "_we"},    64'(bus.rf_we),         64'(m_we));
      check({tag, "_waddr"}, 64'(bus.rf_waddr),      64'(m_addr));
      check({tag, "_wdata"}, 64'(bus.rf_wdata),      64'(m_data));
      check({tag, "_fv"},    64'(bus.fwd_valid),     64'(m_we));
      check({tag, "_fa"},    64'(bus.fwd_addr),      64'(m_addr));
      check({tag, "_fd"},    64'(bus.fwd_data),      64'(m_data));
      check({tag, "_cnt"},   64'(bus.retired_count), 64'(m_count));
   endtask

   initial begin
      m_we = 0; m_addr = 0; m_data = 0; m_count = 0;
      set_in(0, 0, 1, 1, 32'h1234_5678, 32'h9, 2'b10, 0, 2'd0, 1, 4'd3);
      @(negedge clk);
      step("reset0");
      step("reset1");
      rst = 1'b1;

      // Directed selection cases
      set_in(0, 0, 1, 0, 32'h00AA_BBCC, 32'h0000_1122, 2'b10, 0, 2'd0, 1, 4'd1);
      check_comb("t1");
      check("t1_const", 64'(bus.selected_data), 64'h0000_1122);
      step("t1");
      check("t1_wdata_const", 64'(bus.rf_wdata), 64'h0000_1122);
      set_in(0, 0, 1, 1, 32'h0011_1111, 32'h0011_2222, 2'b10, 0, 2'd0, 1, 4'd2);
      check_comb("t2");
      check("t2_const", 64'(bus.selected_data), 64'h0011_1111);
      step("t2");
      set_in(0, 0, 1, 1, 32'h8000_FF80, 32'h0, 2'b00, 1, 2'd0, 1, 4'd3);
      check_comb("t3bs");
      check("t3bs_const", 64'(bus.selected_data), 64'hFFFF_FF80);
      bus.load_signed = 0;
      check_comb("t3bu");
      check("t3bu_const", 64'(bus.selected_data), 64'h0000_0080);
      bus.load_size = 2'b01; bus.load_signed = 1; bus.byte_offset = 2'd2;
      check_comb("t3h2");
      check("t3h2_const", 64'(bus.selected_data), 64'hFFFF_8000);
      bus.load_signed = 0; bus.byte_offset = 2'd1;
      check_comb("t3h1");
      check("t3h1_mis", 64'(bus.misaligned), 64'h1);
      check("t3h1_const", 64'(bus.selected_data), 64'h0000_FF80);
      step("t3");

      // Stall holds, then a single commit on release
      set_in(1, 0, 1, 0, 32'h0, 32'hCAFE_0005, 2'b10, 0, 2'd0, 1, 4'd5);
      step("t4s0");
      step("t4s1");
      check("t4s_we0", 64'(bus.rf_we), 64'h0);
      bus.stall = 0;
      step("t4r");
      check("t4r_we1", 64'(bus.rf_we), 64'h1);
      check("t4r_addr5", 64'(bus.rf_waddr), 64'h5);
      bus.in_valid = 0;
      step("t4idle");

      // Flush beats stall; reset beats everything
      set_in(1, 1, 1, 1, 32'hFFFF_FFFF, 32'h7, 2'b00, 1, 2'd3, 1, 4'd9);
      step("t5f");
      set_in(0, 0, 1, 0, 32'h0, 32'h1111_2222, 2'b10, 0, 2'd0, 1, 4'd0);
      step("t5addr0");
      rst = 1'b0;
      step("t5r0");
      step("t5r1");
      check("t5r_cnt0", 64'(bus.retired_count), 64'h0);
      rst = 1'b1;

      // Counter wrap from all-ones
      force dut.count_q = 32'hFFFF_FFFF;
      #1;
      release dut.count_q;
      m_count = 32'hFFFF_FFFF;
      set_in(0, 0, 1, 0, 32'h0, 32'h55, 2'b10, 0, 2'd0, 0, 4'd7);
      step("t6");
      check("t6_wrap", 64'(bus.retired_count), 64'h0);

      // Randomized traffic against the reference model
      for (int i = 0; i < 200; i++) begin
         set_in(($urandom % 5) == 0, ($urandom % 7) == 0, 1'($urandom), 1'($urandom), $urandom, $urandom,
                2'($urandom), 1'($urandom), 2'($urandom), 1'($urandom), 4'($urandom));
         if (($urandom % 50) == 0) rst = 1'b0; else rst = 1'b1;
         check_comb("rnd");
         step("rnd");
      end
      rst = 1'b1;

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule
